// File: rtl/riscv_instr_mem_responder.sv
// riscv_instr_mem_responder: instruction-fetch responder with PMP window check,
// 1-cycle SRAM read and an in-order response FIFO sized to the outstanding limit.
`default_nettype none

module riscv_instr_mem_responder #(
  parameter int          RDATA_WIDTH = 32,
  parameter int          ADDR_WIDTH  = 14,
  parameter int          DEPTH       = 2,
  parameter logic [31:0] PMP_BASE    = 32'h0000_0000,
  parameter logic [31:0] PMP_TOP     = 32'h0001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_req_i,
  input  logic [31:0]            instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_err_pmp_o,
  output logic                   instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0] instr_rdata_o,
  input  logic                   gnt_stall_i,
  input  logic                   rsp_stall_i,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [RDATA_WIDTH-1:0] mem_rdata_i,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic                   in_range;
  logic                   gnt;
  logic                   rvalid;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   pend_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       fifo_cnt_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [RDATA_WIDTH-1:0] fifo_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_range   = (instr_addr_i >= PMP_BASE) && (instr_addr_i < PMP_TOP);
  assign fifo_empty = (fifo_cnt_q == '0);

  // While rst is high the count is about to clear, so only the range and stall gate the grant.
  assign gnt    = instr_req_i & in_range & ~gnt_stall_i & (rst | (count_q < DEPTH_C));
  assign rvalid = ~rst & ~fifo_empty & ~rsp_stall_i;
  assign push   = pend_q;
  assign pop    = rvalid;

  assign instr_gnt_o     = gnt;
  assign instr_err_pmp_o = instr_req_i & ~in_range;
  assign instr_rvalid_o  = rvalid;
  assign instr_rdata_o   = rvalid ? fifo_q[rd_ptr_q] : '0;
  assign mem_req_o       = gnt;
  assign mem_addr_o      = instr_addr_i[ADDR_WIDTH+1:2];
  assign busy_o          = ~rst & (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      count_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pend_q <= gnt;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      case ({gnt, rvalid})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= mem_rdata_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rvalid && !gnt && count_q == '0))
        else $error("outstanding count underflow");
      assert (!(gnt && !rvalid && count_q == DEPTH_C))
        else $error("outstanding count overflow");
      assert (!(push && !pop && fifo_cnt_q == DEPTH_C))
        else $error("response fifo overflow");
    end
  end
`endif

endmodule

`default_nettype wire
